decoder: RTL and testbench



---
 rtl/mcu_pkg.sv | 66 ++++++
 rtl/strobe_edge_detect.sv | 21 ++
 rtl/decoder.sv | 71 +++++++
 tb/tb_decoder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared microcontroller definitions: instruction layout, opcodes, start
// vector encoding and ALU operation select codes.
package mcu_pkg;

    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned OPCODE_W   = 4;
    localparam int unsigned OPERAND_W  = 6;
    localparam int unsigned ALU_SEL_W  = 3;
    localparam int unsigned NUM_STARTS = 7;

    localparam int unsigned OPCODE_MSB = 15;
    localparam int unsigned OPCODE_LSB = 12;
    localparam int unsigned OP1_MSB    = 11;
    localparam int unsigned OP1_LSB    = 6;
    localparam int unsigned OP2_MSB    = 5;
    localparam int unsigned OP2_LSB    = 0;

    localparam logic [OPCODE_W-1:0] OP_NOP      = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_1        = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_2        = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_3        = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_4        = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_5        = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_6        = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_7        = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_ALU_BASE = 4'h8;

    // ALU operation select, taken from opcode[2:0] for ALU opcodes
    localparam logic [ALU_SEL_W-1:0] ALU_SEL_NONE = 3'd0;
    localparam logic [ALU_SEL_W-1:0] ALU_SEL_0    = 3'd0;
    localparam logic [ALU_SEL_W-1:0] ALU_SEL_1    = 3'd1;
    localparam logic [ALU_SEL_W-1:0] ALU_SEL_2    = 3'd2;
    localparam logic [ALU_SEL_W-1:0] ALU_SEL_3    = 3'd3;
    localparam logic [ALU_SEL_W-1:0] ALU_SEL_4    = 3'd4;
    localparam logic [ALU_SEL_W-1:0] ALU_SEL_5    = 3'd5;
    localparam logic [ALU_SEL_W-1:0] ALU_SEL_6    = 3'd6;
    localparam logic [ALU_SEL_W-1:0] ALU_SEL_7    = 3'd7;

    typedef struct packed {
        logic [OPCODE_W-1:0]  opcode;
        logic [OPERAND_W-1:0] op1;
        logic [OPERAND_W-1:0] op2;
    } instr_t;

    typedef logic [NUM_STARTS-1:0] start_vec_t;

    // One-hot start vector; bit 0 is start1. Unknown opcodes select nothing.
    function automatic start_vec_t start_decode(input logic [OPCODE_W-1:0] op);
        start_vec_t s;
        s = '0;
        case (op)
            OP_1: s = 7'b000_0001;
            OP_2: s = 7'b000_0010;
            OP_3: s = 7'b000_0100;
            OP_4: s = 7'b000_1000;
            OP_5: s = 7'b001_0000;
            OP_6: s = 7'b010_0000;
            OP_7: s = 7'b100_0000;
            OP_ALU_BASE, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF:
                s = 7'b001_0000;
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/strobe_edge_detect.sv
// Rising-edge detector for a level strobe: one registered copy plus an AND.
module strobe_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic pulse_c
);

    logic strobe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe;
        end
    end

    assign pulse_c = strobe & ~strobe_q;

endmodule

// File: rtl/decoder.sv
// Instruction decoder: latches operands and ALU select on each IRin rising
// edge and issues one single-cycle start pulse to the selected phase.
module decoder
    import mcu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IRin,
    input  logic [15:0] instruction,
    output logic        start1,
    output logic        start2,
    output logic        start3,
    output logic        start4,
    output logic        start5,
    output logic        start6,
    output logic        start7,
    output logic [5:0]  parameter1,
    output logic [5:0]  parameter2,
    output logic [2:0]  ALU_Sel
);

    instr_t     ir_c;
    logic       load_c;
    start_vec_t start_q;

    assign ir_c = instr_t'(instruction);

    strobe_edge_detect u_load_detect (
        .clk     (clk),
        .rst_n   (rst_n),
        .strobe  (IRin),
        .pulse_c (load_c)
    );

    // Operand and ALU select latches, held between loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parameter1 <= '0;
            parameter2 <= '0;
            ALU_Sel    <= ALU_SEL_NONE;
        end else if (load_c) begin
            parameter1 <= ir_c.op1;
            parameter2 <= ir_c.op2;
            if (ir_c.opcode[OPCODE_W-1]) begin
                ALU_Sel <= ir_c.opcode[ALU_SEL_W-1:0];
            end else begin
                ALU_Sel <= ALU_SEL_NONE;
            end
        end
    end

    // Start register clears on every non-load cycle, giving one-cycle pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= '0;
        end else if (load_c) begin
            start_q <= start_decode(ir_c.opcode);
        end else begin
            start_q <= '0;
        end
    end

    assign start1 = start_q[0];
    assign start2 = start_q[1];
    assign start3 = start_q[2];
    assign start4 = start_q[3];
    assign start5 = start_q[4];
    assign start6 = start_q[5];
    assign start7 = start_q[6];

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for decoder: stimulus queues expected start/field
// snapshots, a negedge monitor compares whenever a start pulse appears.
module tb_decoder;

    logic        clk;
    logic        rst_n;
    logic        IRin;
    logic [15:0] instruction;
    logic        start1, start2, start3, start4, start5, start6, start7;
    logic [5:0]  parameter1;
    logic [5:0]  parameter2;
    logic [2:0]  ALU_Sel;

    int tests;
    int fails;
    logic [21:0] exp_q[$];

    decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .IRin        (IRin),
        .instruction (instruction),
        .start1      (start1),
        .start2      (start2),
        .start3      (start3),
        .start4      (start4),
        .start5      (start5),
        .start6      (start6),
        .start7      (start7),
        .parameter1  (parameter1),
        .parameter2  (parameter2),
        .ALU_Sel     (ALU_Sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] starts();
        return {start7, start6, start5, start4, start3, start2, start1};
    endfunction

    function automatic logic [21:0] observed();
        return {starts(), parameter1, parameter2, ALU_Sel};
    endfunction

    // Expected snapshot: start number s (0 = none), operands, ALU select
    function automatic logic [21:0] mk(input int s, input logic [5:0] p1,
                                       input logic [5:0] p2, input logic [2:0] a);
        logic [6:0] oh;
        oh = (s == 0) ? 7'd0 : 7'(1 << (s - 1));
        return {oh, p1, p2, a};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Strobe IRin for 'hold' edges with the given instruction word
    task automatic pulse(input logic [15:0] ins, input int hold);
        @(posedge clk);
        #1;
        instruction = ins;
        IRin = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        IRin = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Monitor: any start pulse must match the next queued expectation
    always @(negedge clk) begin
        if (starts() != 7'd0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_start", 32'(observed()), 32'd0);
            end else begin
                check("start_snapshot", 32'(observed()), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        IRin = 1'b0;
        instruction = 16'hFFFF;

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1 check("reset_outputs", 32'(observed()), 32'd0);
        idle(2);
        #1 rst_n = 1'b1;
        idle(5);
        #1 check("post_reset_idle", 32'(observed()), 32'd0);

        // start1: 0001_000000_000010
        exp_q.push_back(mk(1, 6'd0, 6'd2, 3'd0));
        pulse(16'b0001_000000_000010, 1);
        idle(2);

        // start5 from opcode 5: 0101_001000_111111
        exp_q.push_back(mk(5, 6'd8, 6'd63, 3'd0));
        pulse(16'b0101_001000_111111, 1);
        idle(2);

        // start3, then instruction changes without a strobe
        exp_q.push_back(mk(3, 6'd0, 6'd5, 3'd0));
        pulse(16'b0011_000000_000101, 1);
        idle(2);
        #1 instruction = 16'hFFFF;
        idle(2);
        #1 instruction = 16'b0111_111111_111111;
        idle(2);
        #1 check("hold_fields", 32'(observed()), 32'(mk(0, 6'd0, 6'd5, 3'd0)));

        // ALU opcode with IRin held 4 cycles: single start5, ALU_Sel=6
        exp_q.push_back(mk(5, 6'd3, 6'd4, 3'd6));
        pulse(16'b1110_000011_000100, 4);
        idle(2);
        #1 check("held_strobe_fields", 32'(observed()), 32'(mk(0, 6'd3, 6'd4, 3'd6)));

        // Remaining phases
        exp_q.push_back(mk(2, 6'd1, 6'd1, 3'd0));
        pulse(16'b0010_000001_000001, 1);
        idle(2);
        exp_q.push_back(mk(4, 6'd21, 6'd42, 3'd0));
        pulse(16'b0100_010101_101010, 1);
        idle(2);
        exp_q.push_back(mk(6, 6'd63, 6'd0, 3'd0));
        pulse(16'b0110_111111_000000, 1);
        idle(2);

        // Back-to-back IRin 1,0,1: start7 then ALU op 1 two cycles later
        exp_q.push_back(mk(7, 6'd1, 6'd2, 3'd0));
        exp_q.push_back(mk(5, 6'd63, 6'd0, 3'd1));
        pulse(16'b0111_000001_000010, 1);
        pulse(16'b1001_111111_000000, 1);
        idle(2);

        // ALU boundary opcodes 0x8 and 0xF
        exp_q.push_back(mk(5, 6'd2, 6'd3, 3'd0));
        pulse(16'b1000_000010_000011, 1);
        idle(2);
        exp_q.push_back(mk(5, 6'd9, 6'd10, 3'd7));
        pulse(16'b1111_001001_001010, 1);
        idle(2);

        // Reset during the start cycle clears everything immediately
        pulse(16'b0011_000110_000111, 1);
        check("start3_before_reset", 32'(starts()), 32'h04);
        #1 rst_n = 1'b0;
        #1 check("reset_mid_start", 32'(observed()), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // NOP: fields latched, no start
        pulse(16'b0000_101010_010101, 1);
        check("nop_no_start", 32'(observed()), 32'(mk(0, 6'd42, 6'd21, 3'd0)));
        idle(2);

        // X opcode: operands latched, no start
        pulse(16'bxxxx_000111_001000, 1);
        check("xop_no_start", 32'(starts()), 32'd0);
        check("xop_operands", 32'({parameter1, parameter2}), 32'({6'd7, 6'd8}));
        idle(2);

        // Reset released while IRin already high: first edge is a load
        exp_q.push_back(mk(6, 6'd43, 6'd60, 3'd0));
        #1 rst_n = 1'b0;
        instruction = 16'b0110_101011_111100;
        IRin = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 IRin = 1'b0;
        idle(4);

        check("pending_expectations", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
